// File: rtl/portal_msg_framer.sv
// portal_msg_framer
//   Buffers one message of payload words, then emits a header beat
//   {method[15:0], len[15:0]} (len = stored payload words + 1) followed by
//   the stored payload words, using valid/ready handshakes on both sides.
//   Words beyond MAX_WORDS are dropped and flagged in sticky err_overflow.
//
// Ports
//   CLK, RST_N          clock, asynchronous active-low reset
//   in_valid/in_ready   producer handshake; in_data payload, in_last end of
//                       message, in_method sampled with the first word only
//   src_rdy/dst_rdy     sink handshake; beat is the outgoing beat
//   err_overflow        sticky overflow flag, cleared only by reset
//   msg_count           messages fully emitted
//
// Configuration
//   PORTAL_FRAMER_STATS_EN  when defined, msg_count counts emitted messages
//                           (wrapping); when undefined msg_count is tied to 0.
module portal_msg_framer #(
  parameter int MAX_WORDS = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [15:0] in_method,
  output logic        src_rdy,
  input  logic        dst_rdy,
  output logic [31:0] beat,
  output logic        err_overflow,
  output logic [31:0] msg_count
);

  localparam int AW = $clog2(MAX_WORDS);
  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] MAX_C  = CW'(MAX_WORDS);
  localparam logic [CW-1:0] ZERO_C = CW'(0);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wcount_q, wcount_d;   // payload words stored
  logic [CW-1:0] rcount_q, rcount_d;   // index of the next payload word to show
  logic [15:0]   method_q, method_d;
  logic          src_rdy_q, src_rdy_d;
  logic          in_ready_q, in_ready_d;
  logic [31:0]   beat_q, beat_d;
  logic          err_overflow_q, err_overflow_d;
  logic [31:0]   mem [MAX_WORDS];

  logic accept_s;
  logic store_s;
  logic tx_s;

  // in_ready_q is only high in FILL, so an accept can only happen there.
  assign accept_s = in_valid && in_ready_q;
  assign store_s  = accept_s && (wcount_q < MAX_C);
  assign tx_s     = src_rdy_q && dst_rdy;

  // Payload buffer; contents survive reset by design.
  always_ff @(posedge CLK) begin
    if (store_s) begin
      mem[wcount_q[AW-1:0]] <= in_data;
    end
  end

  // Next-state and next-output logic for the framing FSM.
  always_comb begin
    state_d        = state_q;
    wcount_d       = wcount_q;
    rcount_d       = rcount_q;
    method_d       = method_q;
    src_rdy_d      = src_rdy_q;
    in_ready_d     = in_ready_q;
    beat_d         = beat_q;
    err_overflow_d = err_overflow_q;
    case (state_q)
      FILL: begin
        if (accept_s) begin
          if (store_s) begin
            wcount_d = wcount_q + ONE_C;
          end else begin
            err_overflow_d = 1'b1;
          end
          // An empty buffer means this is the first word of the message.
          if (wcount_q == ZERO_C) begin
            method_d = in_method;
          end else begin
            method_d = method_q;
          end
          if (in_last) begin
            state_d    = HDR;
            src_rdy_d  = 1'b1;
            in_ready_d = 1'b0;
            rcount_d   = ZERO_C;
            beat_d     = {method_d, 16'(wcount_d) + 16'd1};
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end
      HDR: begin
        if (tx_s) begin
          state_d  = PAYLOAD;
          beat_d   = mem[{AW{1'b0}}];
          rcount_d = ONE_C;
        end else begin
          state_d = HDR;
        end
      end
      PAYLOAD: begin
        if (tx_s) begin
          // rcount_q == wcount_q: the beat just taken was the last stored word.
          if (rcount_q == wcount_q) begin
            state_d    = FILL;
            src_rdy_d  = 1'b0;
            in_ready_d = 1'b1;
            wcount_d   = ZERO_C;
            rcount_d   = ZERO_C;
          end else begin
            beat_d   = mem[rcount_q[AW-1:0]];
            rcount_d = rcount_q + ONE_C;
          end
        end else begin
          state_d = PAYLOAD;
        end
      end
      default: begin
        state_d    = FILL;
        src_rdy_d  = 1'b0;
        in_ready_d = 1'b1;
        wcount_d   = ZERO_C;
        rcount_d   = ZERO_C;
      end
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q        <= FILL;
      wcount_q       <= ZERO_C;
      rcount_q       <= ZERO_C;
      method_q       <= 16'd0;
      src_rdy_q      <= 1'b0;
      in_ready_q     <= 1'b1;
      beat_q         <= 32'd0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wcount_q       <= wcount_d;
      rcount_q       <= rcount_d;
      method_q       <= method_d;
      src_rdy_q      <= src_rdy_d;
      in_ready_q     <= in_ready_d;
      beat_q         <= beat_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign src_rdy      = src_rdy_q;
  assign beat         = beat_q;
  assign err_overflow = err_overflow_q;

`ifdef PORTAL_FRAMER_STATS_EN
  logic [31:0] msg_count_q, msg_count_d;
  logic        msg_done_s;

  assign msg_done_s = (state_q == PAYLOAD) && tx_s && (rcount_q == wcount_q);

  // Count completed messages, wrapping naturally at 2^32.
  always_comb begin
    msg_count_d = msg_count_q;
    if (msg_done_s) begin
      msg_count_d = msg_count_q + 32'd1;
    end else begin
      msg_count_d = msg_count_q;
    end
  end

  // Message counter register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      msg_count_q <= 32'd0;
    end else begin
      msg_count_q <= msg_count_d;
    end
  end

  assign msg_count = msg_count_q;
`else
  assign msg_count = 32'd0;
`endif

endmodule
